// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch front end.
//
// Keeps the fetch PC, issues word fetches over a req/ack handshake, buffers
// returned words in a small FIFO and presents them to decode through a
// registered output slot. Handles redirects from execute, including dropping
// a fetch that is still in flight when the redirect arrives.
//
// Handshake: a transfer happens on a rising edge where imem_req, imem_ack and
// clk_en are all 1; imem_rdata belongs to imem_addr in that same cycle. Once
// imem_req is raised, imem_req/imem_addr hold until that transfer edge.
//
// Ports:
//   clk, sync_rst (sync, active low), clk_en (freezes all state when 0)
//   imem_req/imem_addr (out, registered), imem_ack/imem_rdata (in)
//   redirect/redirect_pc (in)   restart fetch at redirect_pc[31:2]
//   stall (in)                  decode cannot take the slot
//   inst_out/pc_out/invalid     output slot; invalid=1 marks a bubble
//   fsm_state (out)             current FSM state, for debug
//
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched[31:0] and
// perf_discarded[15:0] transfer counters.

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        sync_rst,
    input  logic        clk_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        invalid,
    output logic [1:0]  fsm_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [15:0] perf_discarded
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_FULL    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      pcout_q, pcout_d;
    logic             inv_q, inv_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];

    logic [31:0] redir_target;
    logic        xfer, accept, slot_load, fifo_empty, pop, bypass, push;
    logic        unused_redirect_lsbs;

    assign redir_target         = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign xfer       = req_q & imem_ack;
    // Only a transfer in FETCH without a concurrent redirect keeps its data.
    assign accept     = xfer & (state_q == ST_FETCH) & ~redirect;
    assign slot_load  = inv_q | ~stall;
    assign fifo_empty = (cnt_q == '0);
    assign pop        = ~redirect & slot_load & ~fifo_empty;
    // Empty FIFO and a free slot: the word goes straight to decode.
    assign bypass     = slot_load & fifo_empty & accept;
    assign push       = accept & ~bypass;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        inst_d   = inst_q;
        pcout_d  = pcout_q;
        inv_d    = inv_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;

        // FIFO bookkeeping
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
            else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
        end

        // Output slot
        if (redirect) begin
            inv_d = 1'b1;
        end else if (slot_load) begin
            if (!fifo_empty) begin
                inst_d  = fifo_inst[rd_ptr_q];
                pcout_d = fifo_pc[rd_ptr_q];
                inv_d   = 1'b0;
            end else if (bypass) begin
                inst_d  = imem_rdata;
                pcout_d = pc_q;
                inv_d   = 1'b0;
            end else begin
                inv_d = 1'b1;
            end
        end

        // Fetch FSM. pc_q always holds the address of the next word to request;
        // in DISCARD it already holds the redirect target while addr_q still
        // shows the abandoned request.
        if (redirect) begin
            pc_d = redir_target;
            if (req_q && !xfer) begin
                state_d = ST_DISCARD;
            end else begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                addr_d  = redir_target;
            end
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (xfer) begin
                        pc_d = pc_q + 32'd4;
                        if (cnt_d == CNT_FULL) begin
                            state_d = ST_FULL;
                            req_d   = 1'b0;
                        end else begin
                            req_d  = 1'b1;
                            addr_d = pc_q + 32'd4;
                        end
                    end else begin
                        req_d  = 1'b1;
                        addr_d = pc_q;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                ST_DISCARD: begin
                    if (xfer) begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            inst_q   <= '0;
            pcout_q  <= '0;
            inv_q    <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
            pcout_q  <= pcout_d;
            inv_q    <= inv_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (sync_rst && clk_en && push) begin
            fifo_inst[wr_ptr_q] <= imem_rdata;
            fifo_pc[wr_ptr_q]   <= pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [15:0] perf_discarded_q;

    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
        end else if (clk_en) begin
            if (accept)         perf_fetched_q   <= perf_fetched_q + 32'd1;
            if (xfer && !accept) perf_discarded_q <= perf_discarded_q + 16'd1;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_discarded = perf_discarded_q;
`endif

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign inst_out  = inst_q;
    assign pc_out    = pcout_q;
    assign invalid   = inv_q;
    assign fsm_state = state_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end producer for the decode stage's instruction interface: drives the instruction word, its PC and the invalid (bubble) flag.
- Holds the PC and issues word fetches over a req/ack instruction-memory handshake.
- Buffers returned words in a small FIFO and feeds a registered output slot to decode.
- Handles redirects (branch/jump) from execute, including discarding a fetch that is in flight when the redirect arrives.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- sync_rst  in  1  synchronous active-low reset. Sampled on the rising clk edge; 0 = reset.
- clk_en  in  1  stage enable. When 0, all state is frozen and registered outputs hold.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  32  fetch word address, registered; bits [1:0] always 0.
- imem_ack  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- redirect  in  1  flush the pipeline front end and restart at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] are ignored and treated as 0.
- stall  in  1  decode cannot accept; inst_out, pc_out and invalid must hold.
- inst_out  out  32  instruction to decode.
- pc_out  out  32  PC of inst_out.
- invalid  out  1  1 = inst_out is a bubble; decode treats it as a NOP.

Behaviour:
- All state updates only on rising clk edges with clk_en=1 (reset excepted). Reset has priority over clk_en.
- Reset values:
  - pc=RESET_PC, FIFO empty, state=FETCH.
  - imem_req=0, imem_addr=RESET_PC.
  - inst_out=0, pc_out=0, invalid=1.
- Transfer: occurs on an edge with imem_req & imem_ack & clk_en. Once imem_req=1, imem_req and imem_addr stay stable until the transfer edge. At most one request is outstanding.
- FSM states:
  - FETCH: drive imem_req=1, imem_addr=pc whenever FIFO count < FIFO_DEPTH. On transfer, push {rdata, pc} and set pc+=4; imem_req stays 1 if space remains. The 32-bit PC wraps from 0xFFFF_FFFC to 0.
  - FULL: FIFO count = FIFO_DEPTH; imem_req=0. Return to FETCH on the edge where a pop frees an entry; the request is asserted the following cycle.
  - DISCARD: entered when a redirect arrives while a request is pending and not transferring on that edge. Keep imem_req and imem_addr unchanged. On transfer, drop the data and go to FETCH with pc = latched redirect target.
- Output slot: loads on any edge where (invalid=1 or stall=0).
  - FIFO non-empty: pop the head into inst_out/pc_out and set invalid=0.
  - FIFO empty with a transfer on this edge: bypass the data straight into the slot (one-cycle latency from transfer to visible output).
  - Otherwise: set invalid=1; inst_out and pc_out keep their old values.
- With stall=1 and invalid=0, the slot holds and nothing is popped.
- Redirect (edge with redirect=1 and clk_en=1):
  - FIFO flushed; output slot set to invalid=1; pc = {redirect_pc[31:2], 2'b00}.
  - If no request is pending, the next cycle drives imem_req=1 with the new pc.
  - A transfer completing on the redirect edge is dropped; no DISCARD state is needed.
  - A redirect while already in DISCARD overwrites the latched target.
  - Redirect has priority over stall and over push/pop.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Reset mid-request: imem_req=0 on the next cycle. Memory must tolerate request abandonment on reset.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output perf_fetched [31:0], incremented on every non-dropped transfer.
  - Adds output perf_discarded [15:0], incremented on every dropped transfer.
  - Both counters reset to 0 and wrap silently.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0x100 and memory acking every cycle with rdata=addr^0xA5A5_0000 -> first imem_req at addr 0x100; invalid=0 with inst_out=0xA5A5_0100, pc_out=0x100 one cycle after the first transfer; then consecutive pc_out 0x104, 0x108.
- stall=1 held 6 cycles, FIFO_DEPTH=2 -> output holds 0x100; imem_req drops after 2 buffered words. On release, pc_out advances 0x104, 0x108, 0x10C with no gaps or duplicates.
- Redirect to 0x2002 while a request is pending with the ack delayed 3 cycles -> invalid=1 next cycle; imem_addr unchanged until the ack; that word is dropped; next request addr=0x2000; the first valid pc_out is 0x2000.
- Redirect on the same edge as a transfer -> transferred word never appears on inst_out; the next request is to the redirect target.
- clk_en=0 for 4 cycles mid-stream with ack held high -> no transfer is counted and outputs are frozen. Stream resumes identically afterwards.
- With FETCH_PERF_CNT_EN: 10 fetches plus 1 discard -> perf_fetched=10, perf_discarded=1; after reset both read 0.
